// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : div_arbiter
// Purpose  : Shares one iterative divider among N_REQ requesters. Requests are
//            granted round-robin; the granted request drives the divider's
//            start/busy/result_valid handshake, and the result is returned to
//            the requester that issued it. A zero denominator is answered
//            locally. A divider that never answers is abandoned after
//            TIMEOUT_CYCLES with an error response.
// Ports    : clk, rst (sync, active high)
//            req_valid/req_numerator/req_denominator/req_numerator_signed
//              : packed per-requester request inputs
//            req_ready   : one-hot acceptance pulse
//            resp_valid  : one-hot result pulse; resp_error/quotient/remainder
//            grant_idx   : requester currently owning the divider
//            div_*       : divider operand/start outputs, busy/result inputs
// Revision : 1.0 - initial release
// ============================================================================
module div_arbiter #(
   parameter int N_REQ          = 2,
   parameter int DIV_BITS       = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int IDX_BITS       = $clog2(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DIV_BITS-1:0] req_numerator,
   input  logic [N_REQ*DIV_BITS-1:0] req_denominator,
   input  logic [N_REQ-1:0]          req_numerator_signed,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          resp_valid,
   output logic                      resp_error,
   output logic [DIV_BITS-1:0]       resp_quotient,
   output logic [DIV_BITS-1:0]       resp_remainder,
   output logic [IDX_BITS-1:0]       grant_idx,
   output logic [DIV_BITS-1:0]       div_numerator,
   output logic [DIV_BITS-1:0]       div_denominator,
   output logic                      div_numerator_signed,
   output logic                      div_start,
   input  logic                      div_busy,
   input  logic                      div_result_valid,
   input  logic [DIV_BITS-1:0]       div_quotient,
   input  logic [DIV_BITS-1:0]       div_remainder
);

   localparam int TMR_BITS = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] S_IDLE        = 3'd0;
   localparam logic [2:0] S_ISSUE       = 3'd1;
   localparam logic [2:0] S_WAIT_ACK    = 3'd2;
   localparam logic [2:0] S_WAIT_RESULT = 3'd3;
   localparam logic [2:0] S_RESPOND     = 3'd4;

   logic [2:0]          r_state;
   logic [IDX_BITS-1:0] r_last_grant;
   logic [TMR_BITS-1:0] r_timer;

   logic [DIV_BITS-1:0] w_num_arr [N_REQ];
   logic [DIV_BITS-1:0] w_den_arr [N_REQ];

   logic                w_any;
   logic [IDX_BITS-1:0] w_sel;
   logic [IDX_BITS-1:0] w_cand;
   logic [N_REQ-1:0]    w_sel_onehot;
   logic [N_REQ-1:0]    w_gnt_onehot;
   logic                w_den_zero;
   logic [TMR_BITS-1:0] w_timer_inc;
   logic                w_timeout;

   logic [2:0]          w_state_nxt;
   logic [N_REQ-1:0]    w_req_ready_nxt;
   logic [N_REQ-1:0]    w_resp_valid_nxt;
   logic                w_resp_error_nxt;
   logic [DIV_BITS-1:0] w_resp_quotient_nxt;
   logic [DIV_BITS-1:0] w_resp_remainder_nxt;
   logic [IDX_BITS-1:0] w_grant_idx_nxt;
   logic [DIV_BITS-1:0] w_div_numerator_nxt;
   logic [DIV_BITS-1:0] w_div_denominator_nxt;
   logic                w_div_signed_nxt;
   logic                w_div_start_nxt;
   logic [TMR_BITS-1:0] w_timer_nxt;
   logic [IDX_BITS-1:0] w_last_grant_nxt;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_num_arr[gi] = req_numerator[gi*DIV_BITS +: DIV_BITS];
      assign w_den_arr[gi] = req_denominator[gi*DIV_BITS +: DIV_BITS];
   end

   // Round-robin pick: first valid requester after the last one served.
   always_comb begin
      w_any  = 1'b0;
      w_sel  = '0;
      w_cand = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_cand = IDX_BITS'((int'(r_last_grant) + 1 + k) % N_REQ);
         if (!w_any && req_valid[w_cand]) begin
            w_any = 1'b1;
            w_sel = w_cand;
         end
      end
   end

   assign w_sel_onehot = N_REQ'(1) << w_sel;
   assign w_gnt_onehot = N_REQ'(1) << grant_idx;
   assign w_den_zero   = (w_den_arr[w_sel] == '0);
   assign w_timer_inc  = r_timer + 1'b1;
   assign w_timeout    = (w_timer_inc == TMR_BITS'(TIMEOUT_CYCLES));

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state              <= S_IDLE;
         r_last_grant         <= IDX_BITS'(N_REQ - 1);
         r_timer              <= '0;
         req_ready            <= '0;
         resp_valid           <= '0;
         resp_error           <= 1'b0;
         resp_quotient        <= '0;
         resp_remainder       <= '0;
         grant_idx            <= '0;
         div_numerator        <= '0;
         div_denominator      <= '0;
         div_numerator_signed <= 1'b0;
         div_start            <= 1'b0;
      end else begin
         r_state              <= w_state_nxt;
         r_last_grant         <= w_last_grant_nxt;
         r_timer              <= w_timer_nxt;
         req_ready            <= w_req_ready_nxt;
         resp_valid           <= w_resp_valid_nxt;
         resp_error           <= w_resp_error_nxt;
         resp_quotient        <= w_resp_quotient_nxt;
         resp_remainder       <= w_resp_remainder_nxt;
         grant_idx            <= w_grant_idx_nxt;
         div_numerator        <= w_div_numerator_nxt;
         div_denominator      <= w_div_denominator_nxt;
         div_numerator_signed <= w_div_signed_nxt;
         div_start            <= w_div_start_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any) w_state_nxt = w_den_zero ? S_RESPOND : S_ISSUE;
         end
         S_ISSUE:       w_state_nxt = S_WAIT_ACK;
         S_WAIT_ACK: begin
            // A result_valid seen here may be left over from the previous
            // operation, so only busy moves us on.
            if (div_busy || w_timeout) w_state_nxt = div_busy ? S_WAIT_RESULT : S_RESPOND;
         end
         S_WAIT_RESULT: begin
            if (div_result_valid || w_timeout) w_state_nxt = S_RESPOND;
         end
         S_RESPOND:     w_state_nxt = S_IDLE;
         default:       w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs. Pulses default low, data holds.
   always_comb begin
      w_req_ready_nxt       = '0;
      w_resp_valid_nxt      = '0;
      w_resp_error_nxt      = resp_error;
      w_resp_quotient_nxt   = resp_quotient;
      w_resp_remainder_nxt  = resp_remainder;
      w_grant_idx_nxt       = grant_idx;
      w_div_numerator_nxt   = div_numerator;
      w_div_denominator_nxt = div_denominator;
      w_div_signed_nxt      = div_numerator_signed;
      w_div_start_nxt       = div_start;
      w_timer_nxt           = r_timer;
      w_last_grant_nxt      = r_last_grant;
      case (r_state)
         S_IDLE: begin
            w_div_start_nxt = 1'b0;
            if (w_any) begin
               w_grant_idx_nxt       = w_sel;
               w_req_ready_nxt       = w_sel_onehot;
               w_div_numerator_nxt   = w_num_arr[w_sel];
               w_div_denominator_nxt = w_den_arr[w_sel];
               w_div_signed_nxt      = req_numerator_signed[w_sel];
               if (w_den_zero) begin
                  // Answered locally; the divider never sees this request.
                  w_resp_valid_nxt     = w_sel_onehot;
                  w_resp_error_nxt     = 1'b0;
                  w_resp_quotient_nxt  = '1;
                  w_resp_remainder_nxt = w_num_arr[w_sel];
               end else begin
                  w_div_start_nxt = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            w_div_start_nxt = 1'b1;
            w_timer_nxt     = '0;
         end
         S_WAIT_ACK, S_WAIT_RESULT: begin
            w_timer_nxt = w_timer_inc;
            if (r_state == S_WAIT_ACK && div_busy) begin
               w_div_start_nxt = 1'b0;
            end else if (r_state == S_WAIT_RESULT && div_result_valid) begin
               w_resp_valid_nxt     = w_gnt_onehot;
               w_resp_error_nxt     = 1'b0;
               w_resp_quotient_nxt  = div_quotient;
               w_resp_remainder_nxt = div_remainder;
            end else if (w_timeout) begin
               w_div_start_nxt      = 1'b0;
               w_resp_valid_nxt     = w_gnt_onehot;
               w_resp_error_nxt     = 1'b1;
               w_resp_quotient_nxt  = '0;
               w_resp_remainder_nxt = '0;
            end
         end
         S_RESPOND: begin
            w_last_grant_nxt = grant_idx;
         end
         default: begin
            w_div_start_nxt = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_arbiter
// Purpose  : Self-checking bench for div_arbiter with a behavioural divider
//            (busy for 3 cycles after start, optional hang). Expected
//            responses are queued as requests are driven and compared when
//            resp_valid fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_arbiter;

   localparam int N_REQ    = 2;
   localparam int DIV_BITS = 32;
   localparam int TMO      = 8;
   localparam int IDX_BITS = 1;

   logic                      clk;
   logic                      rst;
   logic [N_REQ-1:0]          req_valid;
   logic [N_REQ*DIV_BITS-1:0] req_numerator;
   logic [N_REQ*DIV_BITS-1:0] req_denominator;
   logic [N_REQ-1:0]          req_numerator_signed;
   logic [N_REQ-1:0]          req_ready;
   logic [N_REQ-1:0]          resp_valid;
   logic                      resp_error;
   logic [DIV_BITS-1:0]       resp_quotient;
   logic [DIV_BITS-1:0]       resp_remainder;
   logic [IDX_BITS-1:0]       grant_idx;
   logic [DIV_BITS-1:0]       div_numerator;
   logic [DIV_BITS-1:0]       div_denominator;
   logic                      div_numerator_signed;
   logic                      div_start;
   logic                      div_busy;
   logic                      div_result_valid;
   logic [DIV_BITS-1:0]       div_quotient;
   logic [DIV_BITS-1:0]       div_remainder;

   div_arbiter #(
      .N_REQ          (N_REQ),
      .DIV_BITS       (DIV_BITS),
      .TIMEOUT_CYCLES (TMO),
      .IDX_BITS       (IDX_BITS)
   ) u_dut (
      .clk                  (clk),
      .rst                  (rst),
      .req_valid            (req_valid),
      .req_numerator        (req_numerator),
      .req_denominator      (req_denominator),
      .req_numerator_signed (req_numerator_signed),
      .req_ready            (req_ready),
      .resp_valid           (resp_valid),
      .resp_error           (resp_error),
      .resp_quotient        (resp_quotient),
      .resp_remainder       (resp_remainder),
      .grant_idx            (grant_idx),
      .div_numerator        (div_numerator),
      .div_denominator      (div_denominator),
      .div_numerator_signed (div_numerator_signed),
      .div_start            (div_start),
      .div_busy             (div_busy),
      .div_result_valid     (div_result_valid),
      .div_quotient         (div_quotient),
      .div_remainder        (div_remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- checker
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------- divider model
   bit                  hang;
   int                  m_cnt;
   logic [DIV_BITS-1:0] m_a, m_b;
   logic                m_sgn;

   always @(posedge clk) begin
      if (rst) begin
         div_busy         <= 1'b0;
         div_result_valid <= 1'b0;
         div_quotient     <= '0;
         div_remainder    <= '0;
         m_cnt            <= 0;
      end else begin
         div_result_valid <= 1'b0;
         if (div_busy) begin
            if (m_cnt == 1) begin
               div_busy         <= 1'b0;
               div_result_valid <= 1'b1;
               if (m_b == '0) begin
                  div_quotient  <= '1;
                  div_remainder <= m_a;
               end else if (m_sgn) begin
                  div_quotient  <= $signed(m_a) / $signed(m_b);
                  div_remainder <= $signed(m_a) % $signed(m_b);
               end else begin
                  div_quotient  <= m_a / m_b;
                  div_remainder <= m_a % m_b;
               end
            end
            m_cnt <= m_cnt - 1;
         end else if (div_start && !hang) begin
            div_busy <= 1'b1;
            m_cnt    <= 3;
            m_a      <= div_numerator;
            m_b      <= div_denominator;
            m_sgn    <= div_numerator_signed;
         end
      end
   end

   // ------------------------------------------------------------ scoreboard
   typedef struct {
      int                  idx;
      logic [DIV_BITS-1:0] q;
      logic [DIV_BITS-1:0] r;
      logic                err;
   } exp_t;

   exp_t       sb[$];
   exp_t       m_e;
   logic [1:0] m_oh;
   bit         start_seen;

   task automatic push(input int idx, input logic [31:0] q, input logic [31:0] r, input logic err);
      exp_t e;
      e.idx = idx; e.q = q; e.r = r; e.err = err;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (div_start) start_seen = 1'b1;
      if (resp_valid != '0) begin
         check("resp_onehot", 64'($onehot(resp_valid)), 64'd1);
         if (sb.size() == 0) begin
            check("resp_unexpected", 64'(resp_valid), 64'd0);
         end else begin
            m_e  = sb.pop_front();
            m_oh = 2'b01 << m_e.idx;
            check("resp_idx",   64'(resp_valid),     64'(m_oh));
            check("resp_grant", 64'(grant_idx),      64'(m_e.idx));
            check("resp_err",   64'(resp_error),     64'(m_e.err));
            check("resp_quot",  64'(resp_quotient),  64'(m_e.q));
            check("resp_rem",   64'(resp_remainder), 64'(m_e.r));
         end
      end
   end

   // ------------------------------------------------------------ requesters
   int acc    [N_REQ];
   int target [N_REQ];

   task automatic issue(input int i, input logic [31:0] num, input logic [31:0] den,
                        input logic sgn, input int tgt);
      req_numerator[i*DIV_BITS +: DIV_BITS]   = num;
      req_denominator[i*DIV_BITS +: DIV_BITS] = den;
      req_numerator_signed[i]                 = sgn;
      acc[i]       = 0;
      target[i]    = tgt;
      req_valid[i] = 1'b1;
   endtask

   // One clock; inputs are updated just after the edge, requesters drop
   // their request once accepted the required number of times.
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_ready[i]) begin
            acc[i]++;
            if (acc[i] >= target[i]) req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic drain(input string tag, input int budget);
      int c;
      c = 0;
      while ((sb.size() != 0 || req_valid != '0) && c < budget) begin
         step();
         c++;
      end
      check({tag, "_pending"}, 64'(sb.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"},  64'(req_ready),            64'd0);
      check({tag, "_resp_valid"}, 64'(resp_valid),           64'd0);
      check({tag, "_resp_error"}, 64'(resp_error),           64'd0);
      check({tag, "_resp_quot"},  64'(resp_quotient),        64'd0);
      check({tag, "_resp_rem"},   64'(resp_remainder),       64'd0);
      check({tag, "_grant"},      64'(grant_idx),            64'd0);
      check({tag, "_div_num"},    64'(div_numerator),        64'd0);
      check({tag, "_div_den"},    64'(div_denominator),      64'd0);
      check({tag, "_div_sgn"},    64'(div_numerator_signed), 64'd0);
      check({tag, "_div_start"},  64'(div_start),            64'd0);
   endtask

   // ------------------------------------------------------------- sequence
   initial begin
      int n;
      rst                  = 1'b1;
      hang                 = 1'b0;
      start_seen           = 1'b0;
      req_valid            = '0;
      req_numerator        = '0;
      req_denominator      = '0;
      req_numerator_signed = '0;
      for (int i = 0; i < N_REQ; i++) begin acc[i] = 0; target[i] = 0; end
      repeat (3) step();
      check_all_zero("reset");
      rst = 1'b0;
      step();

      // Single unsigned request, cycle-accurate handshake.
      issue(0, 32'd100, 32'd7, 1'b0, 1);
      push(0, 32'd14, 32'd2, 1'b0);
      step();
      check("single_ready", 64'(req_ready), 64'b01);
      check("single_start", 64'(div_start), 64'd1);
      check("single_grant", 64'(grant_idx), 64'd0);
      n = 0;
      while (!div_busy && n < 10) begin step(); n++; end
      check("single_busy_seen", 64'(div_busy), 64'd1);
      step();
      check("single_start_drop", 64'(div_start), 64'd0);
      n = 0;
      while (!div_result_valid && n < 10) begin step(); n++; end
      check("single_rv_seen", 64'(div_result_valid), 64'd1);
      step();
      check("single_resp_cycle", 64'(resp_valid), 64'b01);
      drain("single", 20);

      // Zero denominator: accepted and answered in the same cycle.
      start_seen = 1'b0;
      issue(0, 32'd55, 32'd0, 1'b0, 1);
      push(0, 32'hFFFF_FFFF, 32'd55, 1'b0);
      step();
      check("zero_ready", 64'(req_ready),  64'b01);
      check("zero_resp",  64'(resp_valid), 64'b01);
      check("zero_start", 64'(div_start),  64'd0);
      step();
      check("zero_resp_done", 64'(resp_valid), 64'd0);
      drain("zero", 10);
      check("zero_no_start", 64'(start_seen), 64'd0);

      // Signed request from requester 1: -20 / 3 = -6 rem -2.
      issue(1, 32'hFFFF_FFEC, 32'd3, 1'b1, 1);
      push(1, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 1'b0);
      step();
      check("signed_ready", 64'(req_ready),            64'b10);
      check("signed_grant", 64'(grant_idx),            64'd1);
      check("signed_flag",  64'(div_numerator_signed), 64'd1);
      check("signed_num",   64'(div_numerator),        64'hFFFF_FFEC);
      drain("signed", 30);

      // Contention: both held valid, service alternates 0,1,0,1.
      issue(0, 32'd100, 32'd7, 1'b0, 2);
      issue(1, 32'd90,  32'd4, 1'b0, 2);
      push(0, 32'd14, 32'd2, 1'b0);
      push(1, 32'd22, 32'd2, 1'b0);
      push(0, 32'd14, 32'd2, 1'b0);
      push(1, 32'd22, 32'd2, 1'b0);
      drain("contend", 200);

      // Timeout: divider never acknowledges.
      hang = 1'b1;
      issue(0, 32'd10, 32'd3, 1'b0, 1);
      push(0, 32'd0, 32'd0, 1'b1);
      drain("timeout", 40);
      check("timeout_start_low", 64'(div_start), 64'd0);
      hang = 1'b0;
      step();

      // Reset while waiting for the result: operation abandoned silently.
      issue(1, 32'd50, 32'd5, 1'b0, 1);
      n = 0;
      while (!(div_busy && !div_start) && n < 20) begin step(); n++; end
      check("rstmid_in_wait", 64'(div_busy && !div_start), 64'd1);
      rst = 1'b1;
      step();
      check_all_zero("rstmid");
      step();
      rst = 1'b0;
      step();
      issue(0, 32'd100, 32'd7, 1'b0, 1);
      issue(1, 32'd50,  32'd5, 1'b0, 1);
      push(0, 32'd14, 32'd2, 1'b0);
      push(1, 32'd10, 32'd0, 1'b0);
      step();
      check("post_rst_ready", 64'(req_ready), 64'b01);
      check("post_rst_grant", 64'(grant_idx), 64'd0);
      drain("post_rst", 60);

      repeat (3) step();
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
